// File: rtl/ccu_pkg.sv
// Shared definitions for the CCU command sequencer: command width, the idle
// command, the position of the hold-length field and the FSM state encoding.
package ccu_pkg;

  localparam int CMD_W = 8;
  localparam logic [CMD_W-1:0] NOP_CMD = 8'h00;

  // Hold-length field inside a command: the command stays on cmd_out for
  // (field value + 1) non-stalled cycles.
  localparam int HOLD_MSB = 7;
  localparam int HOLD_LSB = 6;
  localparam int HOLD_W   = HOLD_MSB - HOLD_LSB + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } seq_state_e;

endpackage

// File: rtl/ccu_cmd_sequencer_if.sv
// Bus between the command source / datapath and the sequencer.
// master: command source side; slave: the sequencer itself.
// Optional statistics signals exist only when CCU_SEQ_STATS_EN is defined.
interface ccu_cmd_sequencer_if #(
  parameter int DEPTH = 4,
  parameter int CMD_W = ccu_pkg::CMD_W
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CMD_W-1:0] host_cmd;
  logic             host_valid;
  logic             host_ready;
  logic             flush;
  logic             dp_busy;
  logic [CMD_W-1:0] cmd_out;
  logic             cmd_issue;
  logic             idle;
  logic [CW-1:0]    fifo_count;
`ifdef CCU_SEQ_STATS_EN
  logic [15:0]      issue_count;
  logic [15:0]      stall_count;
`endif

  modport master (
    output host_cmd, host_valid, flush, dp_busy,
`ifdef CCU_SEQ_STATS_EN
    input  issue_count, stall_count,
`endif
    input  host_ready, cmd_out, cmd_issue, idle, fifo_count
  );

  modport slave (
    input  host_cmd, host_valid, flush, dp_busy,
`ifdef CCU_SEQ_STATS_EN
    output issue_count, stall_count,
`endif
    output host_ready, cmd_out, cmd_issue, idle, fifo_count
  );

endinterface

// File: rtl/ccu_cmd_sequencer_cmd_fifo.sv
// cmd_fifo: parameterised synchronous circular FIFO with a synchronous clear.
// Pointers wrap naturally because DEPTH is a power of two. Push is ignored
// when full and pop when empty, so a full FIFO never accepts a push even if
// it is popped in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write port.
  // NOTE: the data array is deliberately not reset; only pointers and count
  // define which entries are valid, so clearing storage would be pure cost.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; clear discards everything.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ccu_cmd_sequencer.sv
// ccu_cmd_sequencer: buffers host commands and issues them one at a time to
// the CCU cmd input, holding each for (cmd[7:6] + 1) non-stalled cycles.
// dp_busy freezes issue and the hold countdown; flush drops queue and the
// current command. Optional macro CCU_SEQ_STATS_EN adds issue/stall counters.
module ccu_cmd_sequencer
  import ccu_pkg::seq_state_e, ccu_pkg::ST_IDLE, ccu_pkg::ST_HOLD,
         ccu_pkg::HOLD_MSB, ccu_pkg::HOLD_LSB, ccu_pkg::HOLD_W;
#(
  parameter int                 DEPTH   = 4,
  parameter int                 CMD_W   = ccu_pkg::CMD_W,
  parameter logic [CMD_W-1:0]   NOP_CMD = ccu_pkg::NOP_CMD
) (
  input logic                 clk,
  input logic                 rst_n,
  ccu_cmd_sequencer_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CMD_W-1:0]  head;
  logic [CW-1:0]     count;

  seq_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              issue_q, issue_d;

  // A push in a flush cycle is discarded; a full FIFO never takes a push.
  assign push = bus.host_valid && !fifo_full && !bus.flush;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (bus.flush),
    .push  (push),
    .pop   (pop),
    .din   (bus.host_cmd),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // Next-state, pop decision and next cmd_out/cmd_issue values.
  // NOTE: every signal gets a default before any branch, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cmd_d   = cmd_q;
    issue_d = 1'b0;
    pop     = 1'b0;
    if (bus.flush) begin
      state_d = ST_IDLE;
      hold_d  = '0;
      cmd_d   = NOP_CMD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty && !bus.dp_busy) begin
            pop     = 1'b1;
            cmd_d   = head;
            issue_d = 1'b1;
            hold_d  = head[HOLD_MSB:HOLD_LSB];
            state_d = (head[HOLD_MSB:HOLD_LSB] != '0) ? ST_HOLD : ST_IDLE;
          end else begin
            cmd_d = NOP_CMD;
          end
        end
        ST_HOLD: begin
          if (!bus.dp_busy) begin
            hold_d = hold_q - HOLD_W'(1);
            if (hold_q == HOLD_W'(1)) state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cmd_d   = NOP_CMD;
        end
      endcase
    end
  end

  // FSM state, hold countdown and registered CCU command outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      cmd_q   <= NOP_CMD;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cmd_q   <= cmd_d;
      issue_q <= issue_d;
    end
  end

  assign bus.cmd_out    = cmd_q;
  assign bus.cmd_issue  = issue_q;
  assign bus.host_ready = !fifo_full;
  assign bus.fifo_count = count;
  assign bus.idle       = fifo_empty && (state_q == ST_IDLE) && !issue_q;

`ifdef CCU_SEQ_STATS_EN
  logic [15:0] issue_cnt_q;
  logic [15:0] stall_cnt_q;

  // Issue counter wraps; stall counter saturates. Flush leaves both intact.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop) issue_cnt_q <= issue_cnt_q + 16'd1;
      if (bus.dp_busy && (state_q == ST_HOLD || !fifo_empty) &&
          stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign bus.issue_count = issue_cnt_q;
  assign bus.stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ccu_cmd_sequencer.sv
// Self-checking bench for ccu_cmd_sequencer: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based behavioural model. Honors CCU_SEQ_STATS_EN.
module tb_ccu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam logic [7:0] NOP = 8'h00;

  logic clk;
  logic rst_n;

  ccu_cmd_sequencer_if #(.DEPTH(DEPTH), .CMD_W(8)) bus ();

  ccu_cmd_sequencer #(
    .DEPTH   (DEPTH),
    .CMD_W   (8),
    .NOP_CMD (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // q holds accepted-but-not-issued commands; m_left is how many more
  // non-stalled cycles the command currently on cmd_out must stay there.
  logic [7:0] q[$];
  logic [7:0] m_out;
  bit         m_issue;
  int         m_left;
  int         m_icnt;
  int         m_scnt;
  bit         m_live = 1'b0;
  logic [7:0] m_head;
  bit         m_push;

  always @(posedge clk) begin
    m_live = 1'b1;
    if (!rst_n) begin
      q.delete();
      m_out   = NOP;
      m_issue = 1'b0;
      m_left  = 0;
      m_icnt  = 0;
      m_scnt  = 0;
    end else begin
      if (bus.dp_busy && (m_left > 0 || q.size() > 0) && m_scnt < 65535) m_scnt++;
      if (bus.flush) begin
        q.delete();
        m_out   = NOP;
        m_issue = 1'b0;
        m_left  = 0;
      end else begin
        m_push = bus.host_valid && (q.size() < DEPTH);
        if (m_left > 0) begin
          m_issue = 1'b0;
          if (!bus.dp_busy) m_left--;
        end else if (q.size() > 0 && !bus.dp_busy) begin
          m_head  = q.pop_front();
          m_out   = m_head;
          m_issue = 1'b1;
          m_left  = int'(m_head[7:6]);
          m_icnt  = (m_icnt + 1) % 65536;
        end else begin
          m_out   = NOP;
          m_issue = 1'b0;
        end
        if (m_push) q.push_back(bus.host_cmd);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("cmd_out",    bus.cmd_out,    m_out);
      check("cmd_issue",  bus.cmd_issue,  m_issue);
      check("host_ready", bus.host_ready, q.size() != DEPTH);
      check("fifo_count", bus.fifo_count, q.size());
      check("idle",       bus.idle,       q.size() == 0 && m_left == 0 && !m_issue);
`ifdef CCU_SEQ_STATS_EN
      check("issue_count", bus.issue_count, m_icnt);
      check("stall_count", bus.stall_count, m_scnt);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] c, input bit busy, input bit fl);
    bus.host_valid = v;
    bus.host_cmd   = c;
    bus.dp_busy    = busy;
    bus.flush      = fl;
  endtask

  task automatic lit_out(input string name, input logic [7:0] c, input bit iss);
    check({name, "_cmd"},   bus.cmd_out,   c);
    check({name, "_issue"}, bus.cmd_issue, iss);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 8'h4C, 1'b0, 1'b0);

    // Reset held 3 cycles with a valid command offered.
    for (int i = 0; i < 3; i++) begin
      cycle();
      lit_out("rst", NOP, 1'b0);
      check("rst_ready", bus.host_ready, 1'b1);
      check("rst_count", bus.fifo_count, 0);
      check("rst_idle",  bus.idle, 1'b1);
    end

    // Back-to-back single-cycle commands.
    rst_n = 1'b1;
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    cycle();  lit_out("b2b0", NOP, 1'b0); check("b2b_count", bus.fifo_count, 1);
    bus.host_cmd = 8'h04;
    cycle();  lit_out("b2b1", 8'h02, 1'b1);
    bus.host_cmd = 8'h06;
    cycle();  lit_out("b2b2", 8'h04, 1'b1);
    bus.host_valid = 1'b0;
    cycle();  lit_out("b2b3", 8'h06, 1'b1);
    cycle();  lit_out("b2b4", NOP, 1'b0); check("b2b_idle", bus.idle, 1'b1);

    // hold=3 command followed by a single-cycle command.
    drive(1'b1, 8'hC1, 1'b0, 1'b0);
    cycle();  lit_out("h3_0", NOP, 1'b0);
    bus.host_cmd = 8'h0A;
    cycle();  lit_out("h3_1", 8'hC1, 1'b1);
    bus.host_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(); lit_out("h3_hold", 8'hC1, 1'b0);
    end
    cycle();  lit_out("h3_next", 8'h0A, 1'b1);
    cycle();  lit_out("h3_end", NOP, 1'b0);

    // hold=2 command stretched by two busy cycles.
    drive(1'b1, 8'h81, 1'b0, 1'b0);
    cycle();
    bus.host_valid = 1'b0;
    cycle();  lit_out("bz_1", 8'h81, 1'b1);
    bus.dp_busy = 1'b1;
    cycle();  lit_out("bz_2", 8'h81, 1'b0);
    cycle();  lit_out("bz_3", 8'h81, 1'b0);
    bus.dp_busy = 1'b0;
    cycle();  lit_out("bz_4", 8'h81, 1'b0);
    cycle();  lit_out("bz_5", 8'h81, 1'b0);
    cycle();  lit_out("bz_end", NOP, 1'b0);

    // Fill to DEPTH under busy, offer one more, then drain.
    drive(1'b1, 8'h11, 1'b1, 1'b0);
    cycle();
    bus.host_cmd = 8'h12; cycle();
    bus.host_cmd = 8'h13; cycle();
    bus.host_cmd = 8'h14; cycle();
    check("full_ready", bus.host_ready, 1'b0);
    check("full_count", bus.fifo_count, 4);
    bus.host_cmd = 8'h15; cycle();
    check("full_reject", bus.fifo_count, 4);
    lit_out("full_nop", NOP, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    cycle();  lit_out("dr_1", 8'h11, 1'b1); check("dr_ready", bus.host_ready, 1'b1);
    check("dr_count", bus.fifo_count, 3);
    cycle();  lit_out("dr_2", 8'h12, 1'b1);
    cycle();  lit_out("dr_3", 8'h13, 1'b1);
    cycle();  lit_out("dr_4", 8'h14, 1'b1);
    cycle();  lit_out("dr_end", NOP, 1'b0);

    // Flush during the hold of 8'h41 with two more commands queued.
    drive(1'b1, 8'h41, 1'b1, 1'b0);
    cycle();
    bus.host_cmd = 8'h05; cycle();
    bus.host_cmd = 8'h06; cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    cycle();  lit_out("fl_0", 8'h41, 1'b1); check("fl_q", bus.fifo_count, 2);
`ifdef CCU_SEQ_STATS_EN
    check("fl_icnt_pre", bus.issue_count, 11);
`endif
    drive(1'b1, 8'h07, 1'b1, 1'b1);
    cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    lit_out("fl_1", NOP, 1'b0);
    check("fl_count", bus.fifo_count, 0);
    check("fl_idle",  bus.idle, 1'b1);
`ifdef CCU_SEQ_STATS_EN
    check("fl_icnt_post", bus.issue_count, 11);
`endif

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 63) == 0);
      cycle();
    end
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (8) cycle();
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
